// File: rtl/swb_pkg.sv
// Shared widths and types for the store write buffer (store_write_buffer, swb_fifo).
package swb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } swb_entry_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } swb_state_e;

endpackage

// File: rtl/swb_fifo.sv
// Entry storage for the store write buffer: wrapping pointers, occupancy count, full/empty.
// With SWB_FWD_EN the raw entries and head pointer are exported for store-to-load forwarding.
module swb_fifo
   import swb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  swb_entry_t       wdata,
   output swb_entry_t       head,
`ifdef SWB_FWD_EN
   output swb_entry_t       entries [DEPTH],
   output logic [PTR_W-1:0] head_ptr,
`endif
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   swb_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally at DEPTH (power of two); count is kept separately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

`ifdef SWB_FWD_EN
   assign entries  = mem;
   assign head_ptr = rd_ptr;
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the core data port and memory/MMIO, with stall and drain/fence.
// Optional store-to-load forwarding (fwd_hit/fwd_data) is built when SWB_FWD_EN is defined.
module store_write_buffer
   import swb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              stall,
   input  logic              drain_req,
   output logic              drain_done,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready,
   output logic              misalign_err,
`ifdef SWB_FWD_EN
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
`endif
   output logic [CNT_W-1:0]  count
);

   swb_state_e state;
   swb_state_e state_nx;
   swb_entry_t push_entry;
   swb_entry_t head;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;
   logic       full_nx;

`ifdef SWB_FWD_EN
   localparam int unsigned PTR_W = $clog2(DEPTH);
   swb_entry_t       entries [DEPTH];
   logic [PTR_W-1:0] head_ptr;
`endif

   assign push = MemWrite & ~stall & (DataAdr[1:0] == 2'b00);
   assign pop  = wr_valid & wr_ready;

   always_comb begin
      push_entry.addr = DataAdr;
      push_entry.data = WriteData;
   end

   swb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (reset_n),
      .push     (push),
      .pop      (pop),
      .wdata    (push_entry),
      .head     (head),
`ifdef SWB_FWD_EN
      .entries  (entries),
      .head_ptr (head_ptr),
`endif
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   // Head is presented straight from storage; idle bus reads as zero.
   assign wr_valid = ~empty;
   assign wr_addr  = wr_valid ? head.addr : '0;
   assign wr_data  = wr_valid ? head.data : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= state_nx;
      end
   end

   // A push can never land while full, so a full buffer only leaves full by popping.
   always_comb begin
      state_nx = state;
      full_nx  = full ? ~pop : ((count == CNT_W'(DEPTH - 1)) & push & ~pop);
      unique case (state)
         RUN:     if (drain_req) state_nx = DRAIN;
         DRAIN:   if (count == '0) state_nx = DONE;
         DONE:    state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall        <= 1'b0;
         drain_done   <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         stall        <= full_nx | (state_nx == DRAIN);
         drain_done   <= (state_nx == DONE);
         misalign_err <= misalign_err | (MemWrite & (DataAdr[1:0] != 2'b00));
      end
   end

`ifdef SWB_FWD_EN
   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         if ((CNT_W'(k) < count) && (entries[head_ptr + PTR_W'(k)].addr == DataAdr)) begin
            fwd_hit  = 1'b1;
            fwd_data = entries[head_ptr + PTR_W'(k)].data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: stores push expected writes, a monitor checks the drain side.
module tb_store_write_buffer;
   import swb_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              clk        = 1'b0;
   logic              reset_n    = 1'b1;
   logic              MemWrite   = 1'b0;
   logic [ADDR_W-1:0] DataAdr    = '0;
   logic [DATA_W-1:0] WriteData  = '0;
   logic              drain_req  = 1'b0;
   logic              wr_ready   = 1'b0;
   logic              stall;
   logic              drain_done;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              misalign_err;
   logic [CNT_W-1:0]  count;
`ifdef SWB_FWD_EN
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
`endif

   logic [63:0] exp_q[$];
   int          n_total = 0;
   int          n_pass  = 0;
   int          zero_at;
   int          done_at;
   int          pulses;

   always #5 clk = ~clk;

   store_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .MemWrite     (MemWrite),
      .DataAdr      (DataAdr),
      .WriteData    (WriteData),
      .stall        (stall),
      .drain_req    (drain_req),
      .drain_done   (drain_done),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .misalign_err (misalign_err),
`ifdef SWB_FWD_EN
      .fwd_hit      (fwd_hit),
      .fwd_data     (fwd_data),
`endif
      .count        (count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Core-side store: hold while stalled, then retire on the next edge.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      DataAdr   = a;
      WriteData = d;
      for (int i = 0; i < 50 && stall; i++) tick();
      if (stall) chk("store_stall_timeout", 64'(stall), 64'd0);
      if (a[1:0] == 2'b00) exp_q.push_back({a, d});
      tick();
      MemWrite = 1'b0;
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (count != '0 && n < 100) begin
         tick();
         n++;
      end
      chk(tag, 64'(count), 64'd0);
   endtask

   // Monitor: every accepted downstream write must match the oldest expected store.
   always @(negedge clk) begin : mon
      logic [63:0] e;
      if (reset_n && wr_valid && wr_ready) begin
         chk("exp_available", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e[63:32]));
            chk("wr_data", 64'(wr_data), 64'(e[31:0]));
         end
      end
   end

   initial begin
      #1 reset_n = 1'b0;
      #2;
      chk("rst_count",    64'(count),        64'd0);
      chk("rst_wr_valid", 64'(wr_valid),     64'd0);
      chk("rst_wr_addr",  64'(wr_addr),      64'd0);
      chk("rst_wr_data",  64'(wr_data),      64'd0);
      chk("rst_stall",    64'(stall),        64'd0);
      chk("rst_done",     64'(drain_done),   64'd0);
      chk("rst_misalign", 64'(misalign_err), 64'd0);
      tick();
      tick();
      reset_n = 1'b1;

      // Single store into an empty buffer
      wr_ready = 1'b1;
      do_store(32'd100, 32'd10);
      chk("t1_valid", 64'(wr_valid), 64'd1);
      chk("t1_count", 64'(count),    64'd1);
      tick();
      chk("t1_count_after", 64'(count), 64'd0);

      // Fill to full with back-pressure; fifth store held by the core
      wr_ready = 1'b0;
      do_store(32'd96,  32'd1);
      do_store(32'd100, 32'd2);
      do_store(32'd104, 32'd3);
      chk("t2_stall_3", 64'(stall), 64'd0);
      do_store(32'd108, 32'd4);
      chk("t2_stall_4", 64'(stall), 64'd1);
      chk("t2_count_4", 64'(count), 64'd4);
      MemWrite  = 1'b1;
      DataAdr   = 32'd112;
      WriteData = 32'd5;
      exp_q.push_back({32'd112, 32'd5});
      tick();
      tick();
      chk("t2_held_count", 64'(count), 64'd4);
      chk("t2_held_stall", 64'(stall), 64'd1);
      wr_ready = 1'b1;
      tick();
      chk("t2_no_pushthru", 64'(count), 64'd3);
      chk("t2_stall_drop",  64'(stall), 64'd0);
      tick();
      MemWrite = 1'b0;
      chk("t2_push_pop", 64'(count), 64'd3);
      wait_empty("t2_empty");

      // Simultaneous push/pop at count=2, streaming across several pointer wraps
      wr_ready = 1'b0;
      do_store(32'd200, 32'd1000);
      do_store(32'd204, 32'd1001);
      chk("t3_count_2", 64'(count), 64'd2);
      wr_ready = 1'b1;
      for (int i = 2; i < 14; i++) begin
         do_store(32'd200 + 32'(4 * i), 32'd1000 + 32'(i));
         chk("t3_count_steady", 64'(count), 64'd2);
      end
      wait_empty("t3_empty");

      // Misaligned store is dropped and flagged stickily
      chk("t4_misalign_pre", 64'(misalign_err), 64'd0);
      do_store(32'd98, 32'd55);
      chk("t4_misalign_set", 64'(misalign_err), 64'd1);
      chk("t4_not_queued",   64'(count),        64'd0);
      do_store(32'd104, 32'd7);
      chk("t4_aligned_queued", 64'(count), 64'd1);
      wait_empty("t4_empty");
      chk("t4_misalign_sticky", 64'(misalign_err), 64'd1);

      // Drain with three queued stores
      wr_ready = 1'b0;
      do_store(32'd300, 32'd30);
      do_store(32'd304, 32'd31);
      do_store(32'd308, 32'd32);
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      chk("t5_stall_drain", 64'(stall), 64'd1);
      wr_ready = 1'b1;
      zero_at  = -1;
      done_at  = -1;
      pulses   = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (drain_done) begin
            pulses++;
            if (done_at < 0) done_at = i;
         end
         if (count == '0 && zero_at < 0) zero_at = i;
         if (count != '0) chk("t5_stall_busy", 64'(stall), 64'd1);
      end
      chk("t5_pulses",    64'(pulses),  64'd1);
      chk("t5_zero_at",   64'(zero_at), 64'd3);
      chk("t5_done_time", 64'(done_at), 64'(zero_at + 1));

      // Drain with the buffer already empty: pulse two cycles after the request
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      chk("t5e_done_1",  64'(drain_done), 64'd0);
      chk("t5e_stall_1", 64'(stall),      64'd1);
      tick();
      chk("t5e_done_2",  64'(drain_done), 64'd1);
      tick();
      chk("t5e_done_3",  64'(drain_done), 64'd0);
      chk("t5e_stall_3", 64'(stall),      64'd0);

`ifdef SWB_FWD_EN
      // Forwarding picks the youngest matching entry
      wr_ready = 1'b0;
      do_store(32'd100, 32'd7);
      do_store(32'd100, 32'd9);
      DataAdr = 32'd100;
      #1;
      chk("t6_hit",  64'(fwd_hit),  64'd1);
      chk("t6_data", 64'(fwd_data), 64'd9);
      DataAdr = 32'd104;
      #1;
      chk("t6_miss", 64'(fwd_hit), 64'd0);
      wr_ready = 1'b1;
      wait_empty("t6_empty");
`endif

      // Asynchronous reset with entries pending
      wr_ready = 1'b0;
      do_store(32'd400, 32'd40);
      do_store(32'd404, 32'd41);
      chk("t7_pending", 64'(wr_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t7_valid",    64'(wr_valid),     64'd0);
      chk("t7_count",    64'(count),        64'd0);
      chk("t7_misalign", 64'(misalign_err), 64'd0);
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      tick();
      wr_ready = 1'b1;
      do_store(32'd500, 32'd11);
      chk("t7_restart", 64'(wr_valid), 64'd1);
      wait_empty("t7_empty");
      tick();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
